im_loader: RTL and testbench
============================

# im_loader

Boot-time program loader for the SISC processor: the write side of the instruction memory, which the core only ever reads. It accepts a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit words, writes them into consecutive instruction-memory addresses, and verifies a checksum. It holds the core in reset (drives its active-low `rst_f`) until a load completes cleanly.

## Interface
- `BASE_ADDR`, 16'h0000: instruction-memory address of the first loaded word.
- `TIMEOUT`, 1024: idle cycles allowed mid-frame before error; 0 disables the timeout.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  byte available on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `im_we`  out  1  instruction-memory write strobe, one cycle per word.
- `im_waddr`  out  16  write address.
- `im_wdata`  out  32  write data.
- `cpu_rst_f`  out  1  active-low reset to the sisc core; 1 only after a successful load.
- `done`  out  1  load completed, checksum good (sticky).
- `err`  out  1  checksum mismatch or timeout (sticky).

## Operation
- Frame format: `CNT_HI`, `CNT_LO` (16-bit word count N, big-endian), then 4·N data bytes (MSB first per word), then one checksum byte.
  - Checksum = XOR of every preceding byte in the frame, including the count bytes.
- A byte transfers on any cycle with `in_valid && in_ready`. `in_data` is ignored otherwise.
- FSM states:
  - `S_CNT_HI`: the reset state. On transfer, capture the count MSB, go to `S_CNT_LO`.
  - `S_CNT_LO`: on transfer, capture the count LSB. Go to `S_DATA` if N≠0, else to `S_CSUM`.
  - `S_DATA`: shift bytes into the word assembler. On the 4th byte of a word, issue a write and decrement the remaining-word counter. When it reaches 0, go to `S_CSUM`.
  - `S_CSUM`: on transfer, compare the received byte with the running XOR. Match → `S_DONE`; mismatch → `S_ERR`.
  - `S_DONE`: `done`=1, `cpu_rst_f`=1, `in_ready`=0. Stays here until `rst`.
  - `S_ERR`: `err`=1, `cpu_rst_f`=0, `in_ready`=0. Stays here until `rst`.
- `in_ready` is 1 in `S_CNT_HI`, `S_CNT_LO`, `S_DATA` and `S_CSUM`; 0 otherwise. It is combinational from the state only.
- Address handling:
  - The address counter loads `BASE_ADDR` on reset.
  - It increments by 1 after each write and wraps 16'hFFFF → 16'h0000 silently.
- Timeout:
  - The idle counter runs in every state except `S_CNT_HI`, `S_DONE` and `S_ERR`.
  - It clears on every transfer.
  - Reaching `TIMEOUT` (when nonzero) forces `S_ERR`.
  - Waiting in `S_CNT_HI` before the first byte never times out.
- Reset mid-frame: all state, counters and the XOR clear, and `cpu_rst_f` drops to 0. The partial load is abandoned; words already written stay in memory.

## Timing
- Reset values:
  - `in_ready`=1, `im_we`=0, `im_waddr`=`BASE_ADDR`, `im_wdata`=0.
  - `cpu_rst_f`=0, `done`=0, `err`=0.
  - State is `S_CNT_HI`.
- Write latency: `im_we`, `im_waddr` and `im_wdata` are registered. They are valid in the cycle after the 4th byte of a word is accepted, for exactly one cycle.
- `im_waddr` advances in the cycle after the `im_we` pulse.
- `done`/`cpu_rst_f` rise, or `err` rises, in the cycle after the checksum byte is accepted.
- Timeout `err` rises the cycle after the idle count reaches `TIMEOUT`.
- Maximum throughput is one byte per cycle; gaps in `in_valid` are allowed anywhere.
- The last data word's `im_we` pulse can coincide with acceptance of the checksum byte. Both take effect; there is no conflict.

## Structure
- Shared package `sisc_pkg` holds:
  - the loader state enum;
  - `IM_ADDR_W`=16 and `IM_DATA_W`=32.
- Sub-module `word_asm`:
  - 8→32 big-endian shift assembler with a 2-bit byte index;
  - inputs: `clk`, `rst`, `byte_en`, `byte_in`;
  - outputs: `word_out`, `word_last` (asserted on the 4th byte).
- The top level holds the FSM, word/address/idle counters, XOR accumulator and output registers.

## Test plan
- Clean load:
  - Stimulus: stream 00 02 11 22 33 44 A0 B0 C0 D0 46, back-to-back.
  - Response: writes 0000←11223344, then 0001←A0B0C0D0; `done`=1 and `cpu_rst_f`=1 one cycle after 46; `in_ready`=0 thereafter.
- Bad checksum:
  - Stimulus: same frame with final byte 47.
  - Response: both writes still occur; `err`=1 and `cpu_rst_f` stays 0.
- Empty program:
  - Stimulus: 00 00 00.
  - Response: no `im_we` pulse; `done`=1.
- Stalls and timeout:
  - Stimulus: clean frame with random 0–5 cycle `in_valid` gaps.
  - Response: same writes and `done` as the clean load.
  - Separately, with `TIMEOUT`=8, stop after byte 11: `err`=1 exactly 9 cycles after the last transfer.
- Reset and wrap:
  - Stimulus: assert `rst` after byte 33 of the clean frame, then resend the full frame.
  - Response: writes restart at `BASE_ADDR` and `done`=1.
  - With `BASE_ADDR`=FFFF and N=2: writes go to FFFF, then 0000.

Source files
------------

// File: rtl/sisc_pkg.sv
// sisc_pkg: shared loader state encoding and instruction-memory geometry.
package sisc_pkg;
    localparam int IM_ADDR_W = 16;
    localparam int IM_DATA_W = 32;
    typedef enum logic [2:0] {
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } ld_state_e;
endpackage

// File: rtl/im_loader_word_asm.sv
// word_asm: big-endian 8->32 shift assembler; word_out is the completed word on the 4th byte.
module word_asm
    import sisc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 byte_en,
    input  logic [7:0]           byte_in,
    output logic [IM_DATA_W-1:0] word_out,
    output logic                 word_last
);
    logic [23:0] sh_q, sh_d;
    logic [1:0]  idx_q, idx_d;

    always_comb begin
        sh_d      = byte_en ? {sh_q[15:0], byte_in} : sh_q;
        idx_d     = byte_en ? idx_q + 2'd1 : idx_q;
        word_out  = {sh_q, byte_in};
        word_last = byte_en && (idx_q == 2'd3);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q  <= '0;
            idx_q <= '0;
        end else begin
            sh_q  <= sh_d;
            idx_q <= idx_d;
        end
    end
endmodule

// File: rtl/im_loader.sv
// im_loader: framed byte-stream boot loader writing instruction memory and gating the core reset.
module im_loader
    import sisc_pkg::*;
#(
    parameter logic [IM_ADDR_W-1:0] BASE_ADDR = 16'h0000,
    parameter int unsigned          TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 im_we,
    output logic [IM_ADDR_W-1:0] im_waddr,
    output logic [IM_DATA_W-1:0] im_wdata,
    output logic                 cpu_rst_f,
    output logic                 done,
    output logic                 err
);
    ld_state_e            state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [IM_ADDR_W-1:0] addr_q, addr_d;
    logic                 we_q, we_d;
    logic [IM_DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]           x_q, x_d;
    logic [31:0]          idle_q, idle_d;
    logic                 xfer, running, byte_en, word_last;
    logic [IM_DATA_W-1:0] word;

    assign in_ready  = state_q inside {S_CNT_HI, S_CNT_LO, S_DATA, S_CSUM};
    assign running   = state_q inside {S_CNT_LO, S_DATA, S_CSUM};
    assign xfer      = in_valid && in_ready;
    assign byte_en   = xfer && (state_q == S_DATA);
    assign done      = state_q == S_DONE;
    assign err       = state_q == S_ERR;
    assign cpu_rst_f = done;
    assign im_we     = we_q;
    assign im_waddr  = addr_q;
    assign im_wdata  = wdata_q;

    word_asm u_asm (
        .clk      (clk),
        .rst      (rst),
        .byte_en  (byte_en),
        .byte_in  (in_data),
        .word_out (word),
        .word_last(word_last)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        wdata_d = wdata_q;
        x_d     = xfer ? x_q ^ in_data : x_q;
        addr_d  = we_q ? addr_q + 16'd1 : addr_q;
        idle_d  = (xfer || !running) ? 32'd0 : idle_q + 32'd1;
        case (state_q)
            S_CNT_HI: if (xfer) begin
                cnt_d[15:8] = in_data;
                state_d     = S_CNT_LO;
            end
            S_CNT_LO: if (xfer) begin
                cnt_d[7:0] = in_data;
                state_d    = ({cnt_q[15:8], in_data} == 16'd0) ? S_CSUM : S_DATA;
            end
            S_DATA: if (word_last) begin
                we_d    = 1'b1;
                wdata_d = word;
                cnt_d   = cnt_q - 16'd1;
                state_d = (cnt_q == 16'd1) ? S_CSUM : S_DATA;
            end
            S_CSUM: if (xfer) state_d = (in_data == x_q) ? S_DONE : S_ERR;
            default: ;
        endcase
        // A stalled frame is abandoned even if a byte arrives on the expiry cycle.
        if (TIMEOUT != 0 && running && idle_q == TIMEOUT) state_d = S_ERR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CNT_HI;
            cnt_q   <= '0;
            addr_q  <= BASE_ADDR;
            we_q    <= 1'b0;
            wdata_q <= '0;
            x_q     <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            x_q     <= x_d;
            idle_q  <= idle_d;
        end
    end
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: directed frames against a default loader and a wrapping, short-timeout loader.
module tb_im_loader;
    logic        clk = 1'b0, rst = 1'b1;
    logic        v0, v1, r0, r1, we0, we1, cf0, cf1, dn0, dn1, er0, er1;
    logic [7:0]  d0, d1;
    logic [15:0] wa0, wa1;
    logic [31:0] wd0, wd1;
    int          total = 0, bad = 0, cyc = 0;
    bit          sel;
    logic [7:0]  fr[11];
    int          xc[11];
    logic [47:0] wq0[$], wq1[$];
    int          wc0[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    im_loader dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_data(d0), .in_ready(r0),
        .im_we(we0), .im_waddr(wa0), .im_wdata(wd0), .cpu_rst_f(cf0), .done(dn0), .err(er0)
    );
    im_loader #(.BASE_ADDR(16'hFFFF), .TIMEOUT(8)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_data(d1), .in_ready(r1),
        .im_we(we1), .im_waddr(wa1), .im_wdata(wd1), .cpu_rst_f(cf1), .done(dn1), .err(er1)
    );

    always @(negedge clk) begin
        if (we0 && !rst) begin
            wq0.push_back({wa0, wd0});
            wc0.push_back(cyc);
        end
        if (we1 && !rst) wq1.push_back({wa1, wd1});
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] qat(input bit which, input int i);
        if (which) return (i < wq1.size()) ? wq1[i] : '1;
        return (i < wq0.size()) ? wq0[i] : '1;
    endfunction

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        v0  = 1'b0;
        v1  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wq0.delete();
        wq1.delete();
        wc0.delete();
    endtask

    task automatic send(input logic [7:0] b, input int gap, output int x);
        int n;
        n = 0;
        if (sel) v1 = 1'b0; else v0 = 1'b0;
        repeat (gap) @(negedge clk);
        if (sel) begin v1 = 1'b1; d1 = b; end
        else     begin v0 = 1'b1; d0 = b; end
        while (!(sel ? r1 : r0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready", sel ? r1 : r0, 1);
        @(posedge clk);
        @(negedge clk);
        x = cyc;
        if (sel) v1 = 1'b0; else v0 = 1'b0;
    endtask

    task automatic send_frame(input int n, input int maxgap);
        for (int i = 0; i < n; i++)
            send(fr[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0, xc[i]);
    endtask

    task automatic chk_clean0(input string tag);
        chk({tag, "_done"}, dn0, 1);
        chk({tag, "_cpurst"}, cf0, 1);
        chk({tag, "_err"}, er0, 0);
        chk({tag, "_nwr"}, wq0.size(), 2);
        chk({tag, "_wr0"}, qat(0, 0), {16'h0000, 32'h11223344});
        chk({tag, "_wr1"}, qat(0, 1), {16'h0001, 32'hA0B0C0D0});
    endtask

    initial begin
        int x, t, last;
        v0 = 0; v1 = 0; d0 = 0; d1 = 0; sel = 0;
        fr = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'h46};
        do_reset();
        chk("rst_ready", r0, 1);
        chk("rst_we", we0, 0);
        chk("rst_waddr", wa0, 16'h0000);
        chk("rst_wdata", wd0, 32'h0);
        chk("rst_cpurst", cf0, 0);
        chk("rst_done", dn0, 0);
        chk("rst_err", er0, 0);
        chk("rst_waddr_base", wa1, 16'hFFFF);

        send_frame(11, 0);
        chk_clean0("clean");
        chk("clean_ready", r0, 0);
        chk("clean_wcyc0", (wc0.size() > 0) ? wc0[0] : -1, xc[5]);
        chk("clean_wcyc1", (wc0.size() > 1) ? wc0[1] : -1, xc[9]);
        chk("clean_addr_adv", wa0, 16'h0002);
        repeat (3) @(negedge clk);
        chk("clean_sticky", {dn0, cf0, r0, we0}, 4'b1100);

        do_reset();
        fr[10] = 8'h47;
        send_frame(11, 0);
        fr[10] = 8'h46;
        chk("bad_err", er0, 1);
        chk("bad_cpurst", cf0, 0);
        chk("bad_done", dn0, 0);
        chk("bad_nwr", wq0.size(), 2);
        chk("bad_wr1", qat(0, 1), {16'h0001, 32'hA0B0C0D0});

        do_reset();
        for (int i = 0; i < 3; i++) send(8'h00, 0, x);
        chk("empty_done", dn0, 1);
        chk("empty_cpurst", cf0, 1);
        repeat (2) @(negedge clk);
        chk("empty_nwr", wq0.size(), 0);

        do_reset();
        send_frame(11, 5);
        chk_clean0("stall");

        do_reset();
        send_frame(5, 0);
        do_reset();
        chk("midrst_waddr", wa0, 16'h0000);
        chk("midrst_ready", r0, 1);
        chk("midrst_cpurst", cf0, 0);
        send_frame(11, 0);
        chk_clean0("resend");

        sel = 1;
        do_reset();
        send(8'h00, 0, x);
        send(8'h02, 0, x);
        send(8'h11, 0, last);
        t = 0;
        while (!er1 && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk("tmo_latency", cyc - last, 9);
        chk("tmo_cpurst", cf1, 0);
        chk("tmo_ready", r1, 0);

        do_reset();
        send_frame(11, 0);
        chk("wrap_done", dn1, 1);
        chk("wrap_nwr", wq1.size(), 2);
        chk("wrap_wr0", qat(1, 0), {16'hFFFF, 32'h11223344});
        chk("wrap_wr1", qat(1, 1), {16'h0000, 32'hA0B0C0D0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
